// File: rtl/cmd_dispatcher_pkg.sv
// Shared types and constants for the host-to-CPU command dispatcher.
package cmd_dispatcher_pkg;

    localparam int unsigned CMD_W  = 7;
    localparam int unsigned DATA_W = 8;

    localparam logic [CMD_W-1:0] CMD_NOP = 7'd0;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] d3;
    } cmd_entry_t;

endpackage

// File: rtl/cmd_dispatcher_fifo.sv
// Circular-buffer FIFO holding queued host commands; head is read combinationally.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// Buffers host commands and issues them to the CPU one at a time, tracking completion status.
module cmd_dispatcher
    import cmd_dispatcher_pkg::*;
#(
    parameter int unsigned WIDTH   = DATA_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [CMD_W-1:0]       host_cmd,
    input  logic [WIDTH-1:0]       host_d1,
    input  logic [WIDTH-1:0]       host_d2,
    input  logic [WIDTH-1:0]       host_d3,
    output logic [CMD_W-1:0]       cmd_out,
    output logic [WIDTH-1:0]       dout_1,
    output logic [WIDTH-1:0]       dout_2,
    output logic [WIDTH-1:0]       dout_3,
    input  logic                   cpu_rdy,
    input  logic                   cpu_zero,
    input  logic                   cpu_error,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   done_pulse,
    output logic                   last_zero,
    output logic                   last_error,
    output logic                   timeout_err,
    output logic [7:0]             err_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    cmd_entry_t       push_entry;
    cmd_entry_t       head;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] count_nxt;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CMD_W-1:0] cmd_d;
    logic [WIDTH-1:0] dout1_d, dout2_d, dout3_d;
    logic             busy_d, done_d, lz_d, le_d, to_d, ready_d;
    logic [7:0]       err_d;

    // NOP transfers complete the handshake but never enter the queue.
    assign push       = host_valid && host_ready && (host_cmd != CMD_NOP) && !fifo_full;
    assign push_entry = '{cmd: host_cmd, d1: DATA_W'(host_d1), d2: DATA_W'(host_d2), d3: DATA_W'(host_d3)};
    assign count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);

    cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cmd_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        cmd_d   = CMD_NOP;
        dout1_d = dout_1;
        dout2_d = dout_2;
        dout3_d = dout_3;
        done_d  = 1'b0;
        lz_d    = last_zero;
        le_d    = last_error;
        to_d    = timeout_err;
        err_d   = err_count;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && cpu_rdy) begin
                    pop     = 1'b1;
                    cmd_d   = head.cmd;
                    dout1_d = WIDTH'(head.d1);
                    dout2_d = WIDTH'(head.d2);
                    dout3_d = WIDTH'(head.d3);
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!cpu_rdy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (cpu_rdy) begin
                    lz_d    = cpu_zero;
                    le_d    = cpu_error;
                    done_d  = 1'b1;
                    if (cpu_error && (err_count != 8'hFF)) begin
                        err_d = err_count + 8'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (count_nxt < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cmd_out     <= CMD_NOP;
            dout_1      <= '0;
            dout_2      <= '0;
            dout_3      <= '0;
            busy        <= 1'b0;
            done_pulse  <= 1'b0;
            last_zero   <= 1'b0;
            last_error  <= 1'b0;
            timeout_err <= 1'b0;
            err_count   <= '0;
            host_ready  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_out     <= cmd_d;
            dout_1      <= dout1_d;
            dout_2      <= dout2_d;
            dout_3      <= dout3_d;
            busy        <= busy_d;
            done_pulse  <= done_d;
            last_zero   <= lz_d;
            last_error  <= le_d;
            timeout_err <= to_d;
            err_count   <= err_d;
            host_ready  <= ready_d;
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher: vector table for single transactions plus hand sequences.
module tb_cmd_dispatcher;
    import cmd_dispatcher_pkg::*;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             host_valid;
    logic             host_ready;
    logic [6:0]       host_cmd;
    logic [7:0]       host_d1, host_d2, host_d3;
    logic [6:0]       cmd_out;
    logic [7:0]       dout_1, dout_2, dout_3;
    logic             cpu_rdy, cpu_zero, cpu_error;
    logic             busy;
    logic [2:0]       fifo_count;
    logic             done_pulse, last_zero, last_error, timeout_err;
    logic [7:0]       err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] cmd;
        logic [7:0] d1, d2, d3;
        int         ack;
        int         hold;
        logic       z, e;
        logic       x_done, x_lz, x_le;
        logic [7:0] x_err;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    cmd_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
        .host_d1(host_d1), .host_d2(host_d2), .host_d3(host_d3),
        .cmd_out(cmd_out), .dout_1(dout_1), .dout_2(dout_2), .dout_3(dout_3),
        .cpu_rdy(cpu_rdy), .cpu_zero(cpu_zero), .cpu_error(cpu_error),
        .busy(busy), .fifo_count(fifo_count), .done_pulse(done_pulse),
        .last_zero(last_zero), .last_error(last_error),
        .timeout_err(timeout_err), .err_count(err_count)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] c, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
        host_valid = 1'b1;
        host_cmd   = c;
        host_d1    = a;
        host_d2    = b;
        host_d3    = d;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic wait_cmd(input logic [6:0] c, input string name);
        int n = 0;
        while (cmd_out !== c && n < 10) begin
            tick();
            n++;
        end
        chk(name, 32'(cmd_out), 32'(c));
    endtask

    // Push one command, act as the CPU, and compare the resulting status.
    task automatic run_vec(input vec_t v);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        push(v.cmd, v.d1, v.d2, v.d3);
        wait_cmd(v.cmd, "vec_launch");
        chk("vec_dout1", 32'(dout_1), 32'(v.d1));
        chk("vec_dout2", 32'(dout_2), 32'(v.d2));
        chk("vec_dout3", 32'(dout_3), 32'(v.d3));
        if (v.ack >= 0) begin
            repeat (v.ack) tick();
            cpu_rdy = 1'b0;
            for (int i = 0; i < v.hold; i++) begin
                tick();
                chk("vec_hold_d1", 32'(dout_1), 32'(v.d1));
            end
            cpu_zero  = v.z;
            cpu_error = v.e;
            cpu_rdy   = 1'b1;
        end
        do begin
            tick();
            if (done_pulse) seen = 1'b1;
            n++;
        end while (busy && n < 40);
        chk("vec_idle", 32'(busy), 32'd0);
        chk("vec_done", 32'(seen), 32'(v.x_done));
        chk("vec_last_zero", 32'(last_zero), 32'(v.x_lz));
        chk("vec_last_error", 32'(last_error), 32'(v.x_le));
        chk("vec_err_count", 32'(err_count), 32'(v.x_err));
        chk("vec_timeout_sticky", 32'(timeout_err), 32'd1);
        cpu_zero  = 1'b0;
        cpu_error = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_cmd [5];
        int         idx;
        int         hold_cnt;
        logic       will_push;

        vecs[0] = '{7'h01, 8'h11, 8'h22, 8'h33,  0, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[1] = '{7'h7F, 8'hFF, 8'h00, 8'hAA,  1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
        vecs[2] = '{7'h40, 8'h80, 8'h01, 8'h7E,  2, 4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
        vecs[3] = '{7'h05, 8'h01, 8'h02, 8'h03, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[4] = '{7'h33, 8'hA5, 8'h5A, 8'hC3,  0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[5] = '{7'h2A, 8'h0F, 8'hF0, 8'h55,  1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3};

        reset = 1'b0; host_valid = 1'b0; host_cmd = '0;
        host_d1 = '0; host_d2 = '0; host_d3 = '0;
        cpu_rdy = 1'b1; cpu_zero = 1'b0; cpu_error = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_cmd_out", 32'(cmd_out), 32'd0);
        chk("rst_dout_1", 32'(dout_1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_status", 32'({done_pulse, last_zero, last_error, timeout_err, err_count}), 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_host_ready", 32'(host_ready), 32'd1);

        // First command: latency, single-cycle launch, operand hold, completion
        host_valid = 1'b1; host_cmd = 7'h12; host_d1 = 8'h05; host_d2 = 8'h03; host_d3 = 8'h00;
        tick();
        host_valid = 1'b0;
        chk("t1_count_after_push", 32'(fifo_count), 32'd1);
        chk("t1_nop_before_launch", 32'(cmd_out), 32'd0);
        tick();
        chk("t1_launch_cmd", 32'(cmd_out), 32'h12);
        chk("t1_launch_dout", 32'({dout_1, dout_2, dout_3}), 32'h050300);
        chk("t1_launch_busy", 32'(busy), 32'd1);
        chk("t1_popped", 32'(fifo_count), 32'd0);
        tick();
        chk("t1_cmd_one_cycle", 32'(cmd_out), 32'd0);
        cpu_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_hold_dout_1", 32'(dout_1), 32'h05);
            chk("t1_no_early_done", 32'(done_pulse), 32'd0);
            chk("t1_busy_held", 32'(busy), 32'd1);
        end
        cpu_zero = 1'b1; cpu_rdy = 1'b1;
        tick();
        chk("t1_done", 32'(done_pulse), 32'd1);
        chk("t1_last_zero", 32'(last_zero), 32'd1);
        chk("t1_last_error", 32'(last_error), 32'd0);
        chk("t1_err_count", 32'(err_count), 32'd0);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        cpu_zero = 1'b0;
        tick();
        chk("t1_done_one_cycle", 32'(done_pulse), 32'd0);

        // Launch timeout with a second command queued behind it
        host_valid = 1'b1; host_cmd = 7'h21; host_d1 = 8'h21;
        tick();
        host_cmd = 7'h22; host_d1 = 8'h22;
        tick();
        host_valid = 1'b0;
        chk("to_launch", 32'(cmd_out), 32'h21);
        chk("to_queued", 32'(fifo_count), 32'd1);
        repeat (15) tick();
        chk("to_still_waiting", 32'(busy), 32'd1);
        chk("to_not_yet", 32'(timeout_err), 32'd0);
        tick();
        chk("to_abort_idle", 32'(busy), 32'd0);
        chk("to_flag", 32'(timeout_err), 32'd1);
        chk("to_no_done", 32'(done_pulse), 32'd0);
        chk("to_no_capture", 32'(last_zero), 32'd1);
        tick();
        chk("to_next_issue", 32'(cmd_out), 32'h22);
        chk("to_next_dout", 32'(dout_1), 32'h22);
        cpu_rdy = 1'b0;
        tick(); tick();
        cpu_rdy = 1'b1;
        tick();
        chk("to_next_done", 32'(done_pulse), 32'd1);
        chk("to_next_zero", 32'(last_zero), 32'd0);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Fill FIFO with CPU busy, then drain in order
        cpu_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_cmd[i] = 7'(7'h61 + i);
            push(exp_cmd[i], 8'(8'h90 + i), 8'h00, 8'h00);
            chk("fill_count", 32'(fifo_count), 32'(i + 1));
            if (i == 2) chk("fill_ready_3", 32'(host_ready), 32'd1);
        end
        chk("fill_full_ready", 32'(host_ready), 32'd0);
        exp_cmd[4] = 7'h65;
        host_valid = 1'b1; host_cmd = 7'h65; host_d1 = 8'h94;
        tick(); tick();
        chk("fill_5th_waits", 32'(fifo_count), 32'd4);
        chk("fill_still_full", 32'(host_ready), 32'd0);
        cpu_rdy  = 1'b1;
        idx      = 0;
        hold_cnt = 0;
        for (int t = 0; t < 60; t++) begin
            will_push = host_valid && host_ready;
            tick();
            if (will_push) host_valid = 1'b0;
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) cpu_rdy = 1'b1;
            end else if (cmd_out != CMD_NOP) begin
                if (idx < 5) begin
                    chk("fill_order", 32'(cmd_out), 32'(exp_cmd[idx]));
                    chk("fill_order_dout", 32'(dout_1), 32'(8'h90 + idx));
                end else begin
                    chk("fill_extra_issue", 32'(cmd_out), 32'(CMD_NOP));
                end
                idx++;
                cpu_rdy  = 1'b0;
                hold_cnt = 2;
            end
        end
        chk("fill_issued", 32'(idx), 32'd5);
        chk("fill_drained", 32'(fifo_count), 32'd0);
        chk("fill_5th_accepted", 32'(host_valid), 32'd0);

        // NOP transfer is accepted and discarded
        chk("nop_ready", 32'(host_ready), 32'd1);
        host_valid = 1'b1; host_cmd = 7'd0;
        tick();
        host_valid = 1'b0;
        chk("nop_not_pushed", 32'(fifo_count), 32'd0);
        chk("nop_ready_after", 32'(host_ready), 32'd1);
        tick(); tick();
        chk("nop_no_issue", 32'(cmd_out), 32'd0);
        chk("nop_not_busy", 32'(busy), 32'd0);

        // Asynchronous reset in WAIT_DONE with two entries queued
        push(7'h50, 8'h50, 8'h00, 8'h00);
        push(7'h51, 8'h51, 8'h00, 8'h00);
        push(7'h52, 8'h52, 8'h00, 8'h00);
        cpu_rdy = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_queued", 32'(fifo_count), 32'd2);
        chk("mid_dout", 32'(dout_1), 32'h50);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_dout", 32'({dout_1, dout_2, dout_3}), 32'd0);
        chk("arst_ready", 32'(host_ready), 32'd0);
        chk("arst_status", 32'({last_zero, last_error, timeout_err, err_count}), 32'd0);
        tick();
        reset   = 1'b1;
        cpu_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_no_issue", 32'(cmd_out), 32'd0);
        end
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        chk("post_rst_ready", 32'(host_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
